// File: rtl/addsub_serial_if.sv
// rtl/addsub_serial_if.sv - start/operand/result bundle for the serial adder-subtractor
interface addsub_serial_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic             cout;
  logic             ovf;

  modport master (output en, sub, a, b, input busy, done, out, cout, ovf);
  modport slave  (input en, sub, a, b, output busy, done, out, cout, ovf);
endinterface

// File: rtl/addsub_serial.sv
// rtl/addsub_serial.sv - digit-serial two's-complement adder/subtractor, DIGIT bits per cycle
module addsub_serial #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic           clk,
  input  logic           rst,
  addsub_serial_if.slave bus
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic             carry;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] out_q;
  logic             cout_q;
  logic             ovf_q;
  logic             done_q;
  logic             busy_q;
  logic [DIGIT:0]   dsum;

  assign dsum = {1'b0, a_reg[DIGIT-1:0]} + {1'b0, b_reg[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      count  <= '0;
      carry  <= 1'b0;
      a_reg  <= '0;
      b_reg  <= '0;
      out_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.en) begin
            a_reg  <= bus.a;
            b_reg  <= bus.sub ? ~bus.b : bus.b;
            carry  <= bus.sub;
            out_q  <= '0;
            count  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            busy_q <= 1'b1;
            state  <= ADD;
          end
        end
        ADD: begin
          a_reg <= a_reg >> DIGIT;
          b_reg <= b_reg >> DIGIT;
          out_q <= (out_q >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
          carry <= dsum[DIGIT];
          count <= count + CW'(1);
          if (count == CW'(N - 1)) begin
            // carry into the MSB is recovered as a^b^sum at bit DIGIT-1 of the top digit
            cout_q <= dsum[DIGIT];
            ovf_q  <= a_reg[DIGIT-1] ^ b_reg[DIGIT-1] ^ dsum[DIGIT-1] ^ dsum[DIGIT];
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.out  = out_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_addsub_serial.sv
// tb/tb_addsub_serial.sv - vector bench driving DIGIT=1,2,4 instances with shared stimulus
module tb_addsub_serial;
  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       sub;
  logic [7:0] a;
  logic [7:0] b;

  always #5 clk = ~clk;

  addsub_serial_if #(.WIDTH(8)) if_d1 ();
  addsub_serial_if #(.WIDTH(8)) if_d2 ();
  addsub_serial_if #(.WIDTH(8)) if_d4 ();

  addsub_serial #(.WIDTH(8), .DIGIT(1)) u_d1 (.clk(clk), .rst(rst), .bus(if_d1));
  addsub_serial #(.WIDTH(8), .DIGIT(2)) u_d2 (.clk(clk), .rst(rst), .bus(if_d2));
  addsub_serial #(.WIDTH(8), .DIGIT(4)) u_d4 (.clk(clk), .rst(rst), .bus(if_d4));

  assign if_d1.en = en;  assign if_d1.sub = sub;  assign if_d1.a = a;  assign if_d1.b = b;
  assign if_d2.en = en;  assign if_d2.sub = sub;  assign if_d2.a = a;  assign if_d2.b = b;
  assign if_d4.en = en;  assign if_d4.sub = sub;  assign if_d4.a = a;  assign if_d4.b = b;

  logic [2:0] done_v;
  logic [2:0] busy_v;
  logic [2:0] cout_v;
  logic [2:0] ovf_v;
  logic [7:0] out_v [3];

  assign done_v = {if_d4.done, if_d2.done, if_d1.done};
  assign busy_v = {if_d4.busy, if_d2.busy, if_d1.busy};
  assign cout_v = {if_d4.cout, if_d2.cout, if_d1.cout};
  assign ovf_v  = {if_d4.ovf,  if_d2.ovf,  if_d1.ovf};
  assign out_v[0] = if_d1.out;
  assign out_v[1] = if_d2.out;
  assign out_v[2] = if_d4.out;

  int n_of [3] = '{8, 4, 2};
  int total = 0;
  int passed = 0;

  typedef struct {
    logic       sub;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] out;
    logic       cout;
    logic       ovf;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input int j, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h", name, j, act, exp);
  endtask

  initial begin
    vecs[0] = '{1'b0, 8'h5A, 8'h33, 8'h8D, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};
    vecs[4] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
    vecs[7] = '{1'b1, 8'hC3, 8'h3C, 8'h87, 1'b1, 1'b0};

    rst = 1'b1; en = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 3; j++)
      check("reset_state", j, {busy_v[j], done_v[j], out_v[j], cout_v[j], ovf_v[j]}, 32'h0);

    for (int v = 0; v < 8; v++) begin
      int       done_at [3];
      int       done_cnt [3];
      logic [9:0] cap [3];
      for (int j = 0; j < 3; j++) begin done_at[j] = -1; done_cnt[j] = 0; cap[j] = '0; end
      en = 1'b1; sub = vecs[v].sub; a = vecs[v].a; b = vecs[v].b;
      for (int k = 0; k <= 10; k++) begin
        @(negedge clk);
        if (k == 0) begin
          en = 1'b0; sub = ~sub; a = ~a; b = b + 8'h5C;
        end
        for (int j = 0; j < 3; j++) begin
          if (done_v[j]) begin
            done_at[j] = k;
            done_cnt[j]++;
            cap[j] = {out_v[j], cout_v[j], ovf_v[j]};
          end
        end
      end
      for (int j = 0; j < 3; j++) begin
        check($sformatf("v%0d_latency", v), j, done_cnt[j] == 1 ? done_at[j] : -1, n_of[j]);
        check($sformatf("v%0d_out", v), j, cap[j][9:2], vecs[v].out);
        check($sformatf("v%0d_cout", v), j, cap[j][1], vecs[v].cout);
        check($sformatf("v%0d_ovf", v), j, cap[j][0], vecs[v].ovf);
        check($sformatf("v%0d_hold", v), j, {busy_v[j], out_v[j], cout_v[j], ovf_v[j]},
              {1'b0, vecs[v].out, vecs[v].cout, vecs[v].ovf});
      end
    end

    // en held high: restarts spaced N+2 with a single idle cycle between
    begin
      int first [3];
      int second [3];
      int idle_cnt [3];
      for (int j = 0; j < 3; j++) begin first[j] = -1; second[j] = -1; idle_cnt[j] = 0; end
      en = 1'b1; sub = 1'b0; a = 8'h5A; b = 8'h33;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        for (int j = 0; j < 3; j++) begin
          if (first[j] >= 0 && second[j] < 0 && !busy_v[j]) idle_cnt[j]++;
          if (done_v[j]) begin
            if (first[j] < 0) first[j] = c;
            else if (second[j] < 0) second[j] = c;
          end
        end
      end
      en = 1'b0;
      for (int j = 0; j < 3; j++) begin
        check("b2b_spacing", j, (first[j] >= 0 && second[j] >= 0) ? second[j] - first[j] : -1, n_of[j] + 2);
        check("b2b_idle_gap", j, idle_cnt[j], 1);
      end
      repeat (12) @(negedge clk);
    end

    // reset on the 4th ADD cycle aborts with no done pulse
    begin
      int stray;
      stray = 0;
      en = 1'b1; sub = 1'b0; a = 8'h5A; b = 8'h33;
      @(negedge clk);
      en = 1'b0;
      repeat (3) @(negedge clk);
      check("mid_op_busy", 0, busy_v[0], 1'b1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int j = 0; j < 3; j++)
        check("abort_state", j, {busy_v[j], done_v[j], out_v[j], cout_v[j], ovf_v[j]}, 32'h0);
      for (int c = 0; c < 12; c++) begin
        @(negedge clk);
        if (done_v != 3'b000 || busy_v != 3'b000) stray++;
      end
      check("abort_no_done", 0, stray, 0);
    end

    // reset wins over en in the same cycle
    rst = 1'b1; en = 1'b1; a = 8'h11; b = 8'h22;
    @(negedge clk);
    rst = 1'b0; en = 1'b0;
    for (int j = 0; j < 3; j++)
      check("rst_over_en", j, {busy_v[j], out_v[j]}, 32'h0);
    @(negedge clk);
    for (int j = 0; j < 3; j++)
      check("rst_over_en_idle", j, busy_v[j], 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/addsub_serial.md
ADDSUB_SERIAL -- requirements
Module: addsub_serial

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits; SHALL be >= 2.
REQ-002 Parameter DIGIT, default 1, bits processed per cycle; SHALL be >= 1 and SHALL divide WIDTH exactly.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 en  input  1  start request; sampled only in IDLE.
REQ-006 sub  input  1  mode select, sampled with en: 0 = a+b, 1 = a-b.
REQ-007 a  input  WIDTH  first operand, sampled with en.
REQ-008 b  input  WIDTH  second operand, sampled with en.
REQ-009 busy  output  1  high whenever the state is not IDLE.
REQ-010 done  output  1  one-cycle pulse; result outputs valid.
REQ-011 out  output  WIDTH  result, modulo 2^WIDTH.
REQ-012 cout  output  1  carry out of the MSB; in sub mode, 1 = no borrow.
REQ-013 ovf  output  1  two's-complement signed overflow.

Function
REQ-014 The FSM SHALL have three states: IDLE, ADD, DONE.
REQ-015 Define N = WIDTH/DIGIT; the cycle counter SHALL be clog2(N) bits wide, minimum 1.
REQ-016 IDLE with en=1: SHALL load a_reg=a and b_reg=(sub ? ~b : b), set carry=sub, clear out, count=0, ovf=0, cout=0, then move to ADD.
REQ-017 IDLE with en=0: all registers SHALL hold.
REQ-018 The ADD cycle SHALL add a_reg[DIGIT-1:0] + b_reg[DIGIT-1:0] + carry and place the DIGIT-bit sum into out[WIDTH-1:WIDTH-DIGIT] while out shifts right by DIGIT.
REQ-019 The ADD cycle SHALL shift a_reg and b_reg right by DIGIT, write the digit carry-out to carry, and increment count.
REQ-020 ADD SHALL last exactly N cycles; on the cycle with count==N-1 the next state SHALL be DONE.
REQ-021 The final ADD cycle SHALL write cout = carry out of the top digit and ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
REQ-022 DONE SHALL last exactly one cycle, then go to IDLE unconditionally; done=1 only while in DONE.
REQ-023 Latency: the start is accepted at rising edge E0; done SHALL be high in the cycle after edge EN. Back-to-back ops SHALL start no more often than every N+2 cycles.
REQ-024 en SHALL be ignored in ADD and DONE; no request queueing.
REQ-025 a, b and sub SHALL NOT affect an operation after acceptance.
REQ-026 out, cout and ovf SHALL hold their values from DONE until the next accepted start.
REQ-027 out is not valid while busy=1 and done=0; it SHALL show the partial shifted result.
REQ-028 Arithmetic SHALL wrap modulo 2^WIDTH and SHALL have no saturation.
REQ-029 Carry SHALL propagate between digits only through the carry register.

Reset
REQ-030 rst=1 at a rising edge SHALL force state IDLE and clear count, carry, a_reg, b_reg, out, cout, ovf, done and busy to 0.
REQ-031 rst SHALL take priority over every other input, including en in the same cycle.
REQ-032 Reset mid-operation SHALL abort the operation, produce no done pulse, and return to idle with all outputs 0.

Verification
REQ-033 WIDTH=8, DIGIT=1: a=0x5A, b=0x33, sub=0, en pulse -> done after 8 ADD cycles; out=0x8D, cout=0, ovf=1.
REQ-034 WIDTH=8, DIGIT=1: a=0x10, b=0x20, sub=1 -> out=0xF0, cout=0, ovf=0.
REQ-035 WIDTH=8, DIGIT=4: a=0xFF, b=0x01, sub=0 -> done after 2 ADD cycles; out=0x00, cout=1, ovf=0.
REQ-036 WIDTH=8, DIGIT=2: a=0x80, b=0x01, sub=1 -> out=0x7F, cout=1, ovf=1.
REQ-037 en held high continuously with fixed operands -> done pulses exactly N+2 cycles apart; busy=0 for one cycle between operations.
REQ-038 Assert rst on the 4th ADD cycle -> next cycle busy=0, out=0, and no done pulse until a new en.
